// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: shares one HD44780 character-LCD write bus between two
// requesters. Round-robin arbitration with a per-requester burst lock, plus
// LCD_EN strobe timing (setup, enable-high, hold) with an extended hold after
// clear/home commands.
`timescale 1ns/1ps
module lcd_bus_arbiter #(
    parameter int SETUP_CYC     = 3,
    parameter int EN_HIGH_CYC   = 25,
    parameter int HOLD_CYC      = 2500,
    parameter int LONG_HOLD_CYC = 82000,
    parameter int CNT_W         = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  req_rs,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_last,
    output logic [1:0]  grant,
    output logic [1:0]  ack,
    output logic        busy,
    output logic        lcd_en,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic [7:0]  lcd_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        EN_HI = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Counter reload values; each phase counts down to zero inclusive.
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_HOLD_CYC - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             owner_reg, owner_next;         // current / lock owner
    logic             locked_reg, locked_next;
    logic             last_served_reg, last_served_next;
    logic             last_flag_reg, last_flag_next; // latched req_last
    logic             rs_reg, rs_next;
    logic [7:0]       data_reg, data_next;

    // Per-requester data bytes unpacked for indexed selection.
    logic [7:0] req_byte [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign req_byte[gi] = req_data[gi*8 +: 8];
            // Owner decode: the bus belongs to owner_reg while a transfer is
            // in flight or while a burst lock is held between bytes.
            assign grant[gi] = ((state_reg != IDLE) || locked_reg) && (owner_reg == 1'(gi));
            assign ack[gi]   = (state_reg == DONE) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign busy     = (state_reg != IDLE);
    assign lcd_en   = (state_reg == EN_HI);
    assign lcd_rs   = rs_reg;
    assign lcd_data = data_reg;
    assign lcd_rw   = 1'b0;

    // Clear (0x01) and return-home (0x02/0x03) need the long settle time.
    logic long_cmd;
    assign long_cmd = !rs_reg && ((data_reg == 8'h01) || (data_reg == 8'h02) || (data_reg == 8'h03));

    // Candidate selection: lock owner only, else round-robin on ties.
    logic cand_valid;
    logic cand_id;
    always_comb begin
        cand_valid = 1'b0;
        cand_id    = 1'b0;
        if (locked_reg) begin
            cand_valid = req[owner_reg];
            cand_id    = owner_reg;
        end else if (req == 2'b11) begin
            cand_valid = 1'b1;
            cand_id    = ~last_served_reg;
        end else if (req[0]) begin
            cand_valid = 1'b1;
            cand_id    = 1'b0;
        end else if (req[1]) begin
            cand_valid = 1'b1;
            cand_id    = 1'b1;
        end
    end

    // Next-state logic: accept in IDLE, then time the EN strobe phases.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        owner_next       = owner_reg;
        locked_next      = locked_reg;
        last_served_next = last_served_reg;
        last_flag_next   = last_flag_reg;
        rs_next          = rs_reg;
        data_next        = data_reg;
        case (state_reg)
            IDLE: begin
                if (cand_valid) begin
                    owner_next     = cand_id;
                    rs_next        = req_rs[cand_id];
                    data_next      = req_byte[cand_id];
                    last_flag_next = req_last[cand_id];
                    cnt_next       = SETUP_LOAD;
                    state_next     = SETUP;
                end
            end
            SETUP: begin
                if (cnt_reg == '0) begin
                    cnt_next   = EN_LOAD;
                    state_next = EN_HI;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            EN_HI: begin
                if (cnt_reg == '0) begin
                    cnt_next   = long_cmd ? LONG_LOAD : HOLD_LOAD;
                    state_next = WAIT;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            DONE: begin
                if (last_flag_reg) begin
                    locked_next      = 1'b0;
                    last_served_next = owner_reg;
                end else begin
                    locked_next = 1'b1;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            owner_reg       <= 1'b0;
            locked_reg      <= 1'b0;
            last_served_reg <= 1'b1;
            last_flag_reg   <= 1'b0;
            rs_reg          <= 1'b0;
            data_reg        <= 8'h00;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            owner_reg       <= owner_next;
            locked_reg      <= locked_next;
            last_served_reg <= last_served_next;
            last_flag_reg   <= last_flag_next;
            rs_reg          <= rs_next;
            data_reg        <= data_next;
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: scoreboard bench. Stimulus pushes expected transfers,
// requester drivers feed bytes, and a monitor compares each completed transfer.
`timescale 1ns/1ps
module tb_lcd_bus_arbiter;

    localparam int SETUP_CYC     = 2;
    localparam int EN_HIGH_CYC   = 3;
    localparam int HOLD_CYC      = 4;
    localparam int LONG_HOLD_CYC = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req;
    logic [1:0]  req_rs;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  grant;
    logic [1:0]  ack;
    logic        busy;
    logic        lcd_en;
    logic        lcd_rs;
    logic        lcd_rw;
    logic [7:0]  lcd_data;

    lcd_bus_arbiter #(
        .SETUP_CYC    (SETUP_CYC),
        .EN_HIGH_CYC  (EN_HIGH_CYC),
        .HOLD_CYC     (HOLD_CYC),
        .LONG_HOLD_CYC(LONG_HOLD_CYC),
        .CNT_W        (17)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_rs  (req_rs),
        .req_data(req_data),
        .req_last(req_last),
        .grant   (grant),
        .ack     (ack),
        .busy    (busy),
        .lcd_en  (lcd_en),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] owner_oh;
        logic       rs;
        logic [7:0] data;
        logic       last;
        logic [7:0] lat;
    } exp_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
        logic       last;
    } byte_t;

    exp_t  exp_q[$];
    byte_t q0[$];
    byte_t q1[$];

    int checks    = 0;
    int errors    = 0;
    int ack_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic expect_xfer(input int id, input logic rs, input logic [7:0] d,
                               input logic last, input int lat);
        exp_t e;
        e.owner_oh = (id == 0) ? 2'b01 : 2'b10;
        e.rs       = rs;
        e.data     = d;
        e.last     = last;
        e.lat      = 8'(lat);
        exp_q.push_back(e);
    endtask

    task automatic send(input int id, input logic rs, input logic [7:0] d, input logic last);
        byte_t b;
        b.rs   = rs;
        b.data = d;
        b.last = last;
        if (id == 0) q0.push_back(b);
        else         q1.push_back(b);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || q0.size() != 0 || q1.size() != 0) && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        @(posedge clk);
        #2;
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: %0d transfers still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Requester drivers: hold req with the front byte until that byte's ack.
    initial begin
        req      = 2'b00;
        req_rs   = 2'b00;
        req_data = 16'h0000;
        req_last = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ack[0] && q0.size() > 0) q0.delete(0);
                if (ack[1] && q1.size() > 0) q1.delete(0);
            end
            if (q0.size() > 0) begin
                req[0] = 1'b1; req_rs[0] = q0[0].rs; req_data[7:0] = q0[0].data; req_last[0] = q0[0].last;
            end else begin
                req[0] = 1'b0;
            end
            if (q1.size() > 0) begin
                req[1] = 1'b1; req_rs[1] = q1[0].rs; req_data[15:8] = q1[0].data; req_last[1] = q1[0].last;
            end else begin
                req[1] = 1'b0;
            end
        end
    end

    // Monitor: times each transfer from accept and checks it against the scoreboard.
    initial begin
        logic       busy_prev;
        int         cyc;
        int         en_rise;
        int         en_cnt;
        logic [1:0] acc_grant;
        logic       acc_rs;
        logic [7:0] acc_data;
        logic       post_pend;
        logic [1:0] post_grant;
        exp_t       e;
        busy_prev = 1'b0; cyc = 0; en_rise = -1; en_cnt = 0;
        acc_grant = 2'b00; acc_rs = 1'b0; acc_data = 8'h00;
        post_pend = 1'b0; post_grant = 2'b00;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_prev = 1'b0;
                post_pend = 1'b0;
            end else begin
                if (post_pend) begin
                    check("grant_after_done", 32'(grant), 32'(post_grant));
                    post_pend = 1'b0;
                end
                check("grant_not_both", 32'(grant == 2'b11), 32'd0);
                if (busy && !busy_prev) begin
                    cyc = 0; en_rise = -1; en_cnt = 0;
                    acc_grant = grant; acc_rs = lcd_rs; acc_data = lcd_data;
                end else if (busy) begin
                    cyc++;
                end
                if (busy && lcd_en) begin
                    if (en_rise < 0) en_rise = cyc;
                    en_cnt++;
                end
                if (ack != 2'b00) begin
                    ack_count++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack: ack=%b, required no ack", ack);
                    end else begin
                        e = exp_q.pop_front();
                        $display("xfer ack=%b data=%02h rs=%0d latency=%0d en_rise=%0d en_len=%0d",
                                 ack, lcd_data, lcd_rs, cyc, en_rise, en_cnt);
                        check("ack_owner",      32'(ack),       32'(e.owner_oh));
                        check("grant_accept",   32'(acc_grant), 32'(e.owner_oh));
                        check("grant_done",     32'(grant),     32'(e.owner_oh));
                        check("rs_accept",      32'(acc_rs),    32'(e.rs));
                        check("data_accept",    32'(acc_data),  32'(e.data));
                        check("data_at_ack",    32'(lcd_data),  32'(e.data));
                        check("ack_latency",    32'(cyc),       32'(e.lat));
                        check("en_rise_cycle",  32'(en_rise),   32'(SETUP_CYC));
                        check("en_high_cycles", 32'(en_cnt),    32'(EN_HIGH_CYC));
                        post_pend  = 1'b1;
                        post_grant = e.last ? 2'b00 : e.owner_oh;
                    end
                end
                busy_prev = busy;
            end
        end
    end

    // Directed stimulus.
    initial begin
        int n;
        int base;
        repeat (3) @(posedge clk);
        #2;
        check("rst_grant",    32'(grant),    32'd0);
        check("rst_ack",      32'(ack),      32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_lcd_en",   32'(lcd_en),   32'd0);
        check("rst_lcd_rs",   32'(lcd_rs),   32'd0);
        check("rst_lcd_rw",   32'(lcd_rw),   32'd0);
        check("rst_lcd_data", 32'(lcd_data), 32'd0);
        rst = 1'b0;

        // Single data byte from requester 0.
        expect_xfer(0, 1'b1, 8'h41, 1'b1, 9);
        send(0, 1'b1, 8'h41, 1'b1);
        wait_drain("single", 200);

        // Clear command uses the long hold; function-set uses the normal one.
        expect_xfer(1, 1'b0, 8'h01, 1'b1, 15);
        send(1, 1'b0, 8'h01, 1'b1);
        wait_drain("long_clear", 200);
        expect_xfer(1, 1'b0, 8'h38, 1'b1, 9);
        send(1, 1'b0, 8'h38, 1'b1);
        wait_drain("normal_cmd", 200);
        check("lcd_data_held_idle", 32'(lcd_data), 32'h38);

        // Round-robin with both requesters continuously requesting.
        expect_xfer(0, 1'b1, 8'hA0, 1'b1, 9);
        expect_xfer(1, 1'b1, 8'hB0, 1'b1, 9);
        expect_xfer(0, 1'b1, 8'hA1, 1'b1, 9);
        expect_xfer(1, 1'b1, 8'hB1, 1'b1, 9);
        send(0, 1'b1, 8'hA0, 1'b1);
        send(0, 1'b1, 8'hA1, 1'b1);
        send(1, 1'b1, 8'hB0, 1'b1);
        send(1, 1'b1, 8'hB1, 1'b1);
        wait_drain("round_robin", 400);

        // Locked burst from requester 0 while requester 1 waits.
        base = ack_count;
        expect_xfer(0, 1'b0, 8'h80, 1'b0, 9);
        expect_xfer(0, 1'b1, 8'h11, 1'b0, 9);
        expect_xfer(0, 1'b1, 8'h22, 1'b0, 9);
        expect_xfer(0, 1'b1, 8'h33, 1'b1, 9);
        expect_xfer(1, 1'b1, 8'h55, 1'b1, 9);
        send(0, 1'b0, 8'h80, 1'b0);
        send(0, 1'b1, 8'h11, 1'b0);
        send(0, 1'b1, 8'h22, 1'b0);
        send(0, 1'b1, 8'h33, 1'b1);
        send(1, 1'b1, 8'h55, 1'b1);
        n = 0;
        while (ack_count < base + 4 && n < 300) begin
            @(posedge clk);
            #2;
            n++;
            if (!busy && ack_count > base && ack_count < base + 4)
                check("lock_gap_grant", 32'(grant), 32'h1);
        end
        wait_drain("lock_burst", 300);

        // Requester 0 served last, so a tie would now favour requester 1.
        expect_xfer(0, 1'b1, 8'h61, 1'b1, 9);
        send(0, 1'b1, 8'h61, 1'b1);
        wait_drain("pre_reset", 200);

        // Reset while EN is high: everything drops at once, no ack.
        send(0, 1'b1, 8'h62, 1'b1);
        n = 0;
        while (!lcd_en && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("en_seen_before_reset", 32'(lcd_en), 32'd1);
        rst = 1'b1;
        q0.delete();
        #1;
        check("midrst_lcd_en", 32'(lcd_en), 32'd0);
        check("midrst_grant",  32'(grant),  32'd0);
        check("midrst_busy",   32'(busy),   32'd0);
        check("midrst_ack",    32'(ack),    32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        expect_xfer(0, 1'b1, 8'h70, 1'b1, 9);
        expect_xfer(1, 1'b1, 8'h71, 1'b1, 9);
        send(0, 1'b1, 8'h70, 1'b1);
        send(1, 1'b1, 8'h71, 1'b1);
        wait_drain("post_reset", 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Shares the single HD44780 character-LCD bus between two requesters, for example the text-refresh sequencer and the CGRAM font loader.
- Each requester submits one byte transfer at a time: an RS bit plus 8-bit data.
- The block grants the bus using round-robin arbitration and generates the LCD_EN pulse timing, including the extended wait after clear/home commands.
- Each requester can lock the bus across a multi-byte burst so that another requester cannot interleave bytes in the middle of it.

Parameters:
- SETUP_CYC, 3: cycles with RS/DATA valid and EN low before EN rises. Minimum 1.
- EN_HIGH_CYC, 25: cycles EN is held high. Minimum 1.
- HOLD_CYC, 2500: cycles EN is held low after a normal command or data byte, before ack. Minimum 1.
- LONG_HOLD_CYC, 82000: replaces HOLD_CYC when rs=0 and data is 8'h01, 8'h02 or 8'h03 (clear/home commands).
- CNT_W, 17: width of the timing counter. Must hold the largest value of the other parameters.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- req, input, 2: per-requester transfer request, level. Must be held until that requester's ack.
- req_rs, input, 2: per-requester RS bit.
- req_data, input, 16: per-requester data byte. [7:0] belongs to requester 0, [15:8] to requester 1.
- req_last, input, 2: 1 means this byte ends the requester's burst and releases the lock.
- grant, output, 2: one-hot owner of the bus. Asserted from accept through DONE, and while the bus is locked.
- ack, output, 2: one-cycle pulse to the owner when its transfer completes.
- busy, output, 1: high whenever the state is not IDLE.
- lcd_en, output, 1: LCD enable strobe.
- lcd_rs, output, 1: LCD register select.
- lcd_rw, output, 1: constant 0; the block only writes.
- lcd_data, output, 8: LCD data bus value. Tristating is done outside this block.

Behaviour:
- Reset values: grant=0, ack=0, busy=0, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00. Internally: state=IDLE, lock cleared, last_served=1, so requester 0 wins the first tie.
- Reset asserted mid-transfer: lcd_en drops immediately (asynchronously), the transfer is abandoned and no ack is issued.
- States: IDLE, SETUP, EN_HI, WAIT, DONE.
- IDLE, candidate selection:
  - If locked, only the lock owner's req is considered. The other requester waits, however long that takes.
  - If unlocked and both req are high, the requester other than last_served wins.
  - If unlocked and one req is high, that requester wins.
- IDLE, on the accept edge:
  - Latch req_rs, req_data and req_last of the winner into lcd_rs, lcd_data and an internal last flag.
  - Set grant one-hot and busy=1.
  - Load counter = SETUP_CYC-1 and go to SETUP.
- SETUP: lcd_en=0 for exactly SETUP_CYC cycles. Then load counter = EN_HIGH_CYC-1 and go to EN_HI.
- EN_HI: lcd_en=1 for exactly EN_HIGH_CYC cycles. Then load counter = (long ? LONG_HOLD_CYC : HOLD_CYC)-1 and go to WAIT.
  - long = (lcd_rs==0) and (lcd_data is 8'h01, 8'h02 or 8'h03).
- WAIT: lcd_en=0 for the selected count. Then go to DONE.
- DONE: exactly 1 cycle.
  - ack[owner]=1.
  - If the latched last=1: clear the lock, set last_served=owner, and drop grant at the exit from DONE.
  - If the latched last=0: lock=owner and grant[owner] stays high.
  - Then go to IDLE.
- lcd_rs and lcd_data are held stable from accept through DONE, and keep their value while in IDLE.
- Timing from the accept edge:
  - lcd_en rises SETUP_CYC cycles after accept.
  - lcd_en falls SETUP_CYC+EN_HIGH_CYC cycles after accept.
  - ack is high during cycle SETUP_CYC+EN_HIGH_CYC+hold after accept.
  - Earliest next accept is the cycle after DONE.
- Requester drops req after accept: the transfer completes and ack is still pulsed. Changes to req_* after accept are ignored.
- A locked owner with req low leaves the bus idle and locked. Only a byte with req_last=1 releases the lock.
- ack and grant are never asserted for more than one requester in the same cycle.

Test Plan:
Test parameters: SETUP_CYC=2, EN_HIGH_CYC=3, HOLD_CYC=4, LONG_HOLD_CYC=10.
- Reset release, then req=01, rs0=1, data0=8'h41, last0=1:
  - Required: grant=01 the next cycle; lcd_data=8'h41 and lcd_rs=1.
  - lcd_en high for 3 cycles, starting 2 cycles after accept.
  - ack=01 for one cycle, 9 cycles after accept; grant returns to 0.
- Long wait: req=10, rs1=0, data1=8'h01. Required: same waveform, but ack arrives 15 cycles after accept. Repeat with data1=8'h38: ack at 9 cycles.
- Round-robin fairness: req=11 held with last=1 on both, over 4 transfers. Required: order is 0,1,0,1, and ack alternates 01,10,01,10.
- Lock: requester 0 sends 8'h80 with last0=0, then three data bytes with the final one last0=1, while req1 is held high throughout.
  - Required: all four bytes of requester 0 complete before the first accept of requester 1.
  - grant stays 01 through the inter-byte IDLE gaps.
- Reset mid-transfer: assert rst while lcd_en=1. Required: lcd_en, grant and busy are 0 immediately, with no ack. After release, req=11 grants requester 0 first.
